// File: rtl/trail_rmw_writer_if.sv
// Bus bundle between the trail writer, the game logic that feeds it, and frameRAM.
// The slave side belongs to the writer; the master side belongs to the game logic and the RAM.
interface trail_rmw_writer_if #(
   parameter int V_RES  = 480,
   parameter int ADDR_W = 20,
   parameter int XW     = 10,
   parameter int YW     = 9
);
   logic              req_valid;
   logic              req_ready;
   logic [XW-1:0]     req_x;
   logic [YW-1:0]     req_y;
   logic [1:0]        req_op;
   logic              rsp_valid;
   logic              rsp_hit;
   logic              clear_all;
   logic              busy;
   logic              clear_done;
   logic [ADDR_W-1:0] ram_read_address;
   logic [V_RES-1:0]  ram_data_Out;
   logic [ADDR_W-1:0] ram_write_address;
   logic [V_RES-1:0]  ram_data_In;
   logic              ram_we;

   modport slave (
      input  req_valid, req_x, req_y, req_op, clear_all, ram_data_Out,
      output req_ready, rsp_valid, rsp_hit, busy, clear_done,
             ram_read_address, ram_write_address, ram_data_In, ram_we
   );

   modport master (
      output req_valid, req_x, req_y, req_op, clear_all, ram_data_Out,
      input  req_ready, rsp_valid, rsp_hit, busy, clear_done,
             ram_read_address, ram_write_address, ram_data_In, ram_we
   );
endinterface

// File: rtl/trail_rmw_writer.sv
// Read-modify-write pixel stage in front of frameRAM: one pixel per request,
// returns the old pixel value for collision detection, plus a full-frame clear sweep.
module trail_rmw_writer #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 20,
   parameter int XW     = 10,
   parameter int YW     = 9
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   trail_rmw_writer_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_MOD, ST_SWEEP} state_t;
   typedef enum logic [1:0] {OP_TEST = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_TEST_SET = 2'b11} op_t;

   localparam logic [XW-1:0]    LP_XLIM  = XW'(H_RES);
   localparam logic [XW-1:0]    LP_XLAST = XW'(H_RES - 1);
   localparam logic [YW-1:0]    LP_YLIM  = YW'(V_RES);
   localparam logic [V_RES-1:0] LP_ONE   = V_RES'(1);

   state_t            r_state;
   state_t            w_next;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   op_t               r_op;
   logic [XW-1:0]     r_cnt;
   logic              r_rsp_valid;
   logic              r_rsp_hit;
   logic              r_clear_done;

   logic              w_accept;
   logic              w_oor;
   logic              w_old;
   logic [V_RES-1:0]  w_mask;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_raddr;
   logic [ADDR_W-1:0] w_waddr;
   logic [V_RES-1:0]  w_wdata;

   // Out-of-range pixels never touch RAM and always report as already occupied.
   assign w_oor  = (r_x >= LP_XLIM) | (r_y >= LP_YLIM);
   assign w_old  = w_oor ? 1'b1 : bus.ram_data_Out[r_y];
   assign w_mask = LP_ONE << r_y;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_ram_we = 1'b0;
      w_raddr  = '0;
      w_waddr  = '0;
      w_wdata  = '0;
      case (r_state)
         ST_IDLE: begin
            if (bus.clear_all) begin
               w_next = ST_SWEEP;
            end else if (bus.req_valid) begin
               w_accept = 1'b1;
               w_next   = ST_RD;
            end
         end
         ST_RD: begin
            w_raddr = ADDR_W'(r_x);
            w_next  = ST_MOD;
         end
         ST_MOD: begin
            w_next = ST_IDLE;
            if (!w_oor && (r_op != OP_TEST)) begin
               w_ram_we = 1'b1;
               w_waddr  = ADDR_W'(r_x);
               w_wdata  = (r_op == OP_CLR) ? (bus.ram_data_Out & ~w_mask)
                                           : (bus.ram_data_Out | w_mask);
            end
         end
         ST_SWEEP: begin
            w_ram_we = 1'b1;
            w_waddr  = ADDR_W'(r_cnt);
            if (r_cnt == LP_XLAST) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x          <= '0;
         r_y          <= '0;
         r_op         <= OP_TEST;
         r_cnt        <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_hit    <= 1'b0;
         r_clear_done <= 1'b0;
      end else begin
         r_rsp_valid  <= (r_state == ST_MOD);
         r_rsp_hit    <= (r_state == ST_MOD) ? w_old : 1'b0;
         r_clear_done <= (r_state == ST_SWEEP) && (r_cnt == LP_XLAST);
         if (w_accept) begin
            r_x  <= bus.req_x;
            r_y  <= bus.req_y;
            r_op <= op_t'(bus.req_op);
         end
         if (r_state == ST_SWEEP) begin
            r_cnt <= (r_cnt == LP_XLAST) ? '0 : r_cnt + XW'(1);
         end
      end
   end

   // Reset is folded into ready so nothing is accepted while the block is held in reset.
   assign bus.req_ready         = (r_state == ST_IDLE) & ~bus.clear_all & i_rst_n;
   assign bus.busy              = (r_state != ST_IDLE);
   assign bus.rsp_valid         = r_rsp_valid;
   assign bus.rsp_hit           = r_rsp_hit;
   assign bus.clear_done        = r_clear_done;
   assign bus.ram_we            = w_ram_we;
   assign bus.ram_read_address  = w_raddr;
   assign bus.ram_write_address = w_waddr;
   assign bus.ram_data_In       = w_wdata;

endmodule
